// File: rtl/i2c_xfer_seq_pkg.sv
// Shared types for the I2C transaction sequencer: FSM states, latched
// descriptor fields and the byte-controller command bundle.
package i2c_xfer_seq_pkg;

   typedef enum logic [2:0] {
      IDLE, ADDR, WR_WAIT, WR, RD, RD_HOLD, NACK_STOP, DONE
   } t_seq_state;

   typedef struct packed {
      logic start;
      logic stop;
      logic read;
      logic write;
      logic ack_in;
   } t_cmd;

   typedef struct packed {
      logic rnw;
      logic stop;
      logic len_zero;
   } t_desc;

   localparam t_cmd CMD_NONE = '0;

   // Command bits that go with a state; last = this byte is the final one.
   function automatic t_cmd cmd_for(t_seq_state st, logic last, logic stop_f,
                                    logic len_zero);
      t_cmd c;
      c = CMD_NONE;
      case (st)
         ADDR: begin
            c.start = 1'b1;
            c.write = 1'b1;
            c.stop  = len_zero & stop_f;
         end
         WR: begin
            c.write = 1'b1;
            c.stop  = last & stop_f;
         end
         RD: begin
            c.read   = 1'b1;
            c.ack_in = last;
            c.stop   = last & stop_f;
         end
         NACK_STOP: c.stop = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/i2c_xfer_seq_if.sv
// Command/status bus between the transaction sequencer and the byte controller.
interface i2c_xfer_seq_if;
   logic       start;
   logic       stop;
   logic       read;
   logic       write;
   logic       ack_in;
   logic [7:0] din;
   logic       cmd_ack;
   logic       ack_out;
   logic [7:0] dout;
   logic       i2c_al;
   logic       slave_act;

   modport master (
      output start, stop, read, write, ack_in, din,
      input  cmd_ack, ack_out, dout, i2c_al, slave_act
   );

   modport slave (
      input  start, stop, read, write, ack_in, din,
      output cmd_ack, ack_out, dout, i2c_al, slave_act
   );
endinterface

// File: rtl/i2c_xfer_seq.sv
// Master-side I2C transaction sequencer: turns one descriptor into a
// start/byte/stop command stream for the byte controller.
module i2c_xfer_seq
   import i2c_xfer_seq_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [6:0]       req_addr,
   input  logic             req_rnw,
   input  logic [LEN_W-1:0] req_len,
   input  logic             req_stop,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             done,
   output logic             st_nack,
   output logic             st_al,
   i2c_xfer_seq_if.master   bc
);

   t_seq_state       state, state_nxt;
   t_desc            desc, desc_nxt;
   t_cmd             cmd_q, cmd_nxt;
   logic [LEN_W-1:0] cnt, cnt_nxt;
   logic [7:0]       din_q, din_nxt, rd_data_nxt;
   logic             rd_valid_nxt, st_nack_nxt, st_al_nxt, done_nxt;
   logic             accept, al_hit, cnt_last;

   // The slave path owning the controller keeps us from taking new work.
   assign req_ready = (state == IDLE) & ~bc.slave_act;
   assign accept    = req_valid & req_ready;
   assign al_hit    = bc.i2c_al & (state != IDLE);
   assign wr_ready  = (state == WR_WAIT) & wr_valid & ~bc.i2c_al;
   assign cnt_last  = (cnt == LEN_W'(1));

   assign bc.start  = cmd_q.start;
   assign bc.stop   = cmd_q.stop;
   assign bc.read   = cmd_q.read;
   assign bc.write  = cmd_q.write;
   assign bc.ack_in = cmd_q.ack_in;
   assign bc.din    = din_q;

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state    <= IDLE;
         desc     <= '0;
         cnt      <= '0;
         din_q    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         st_nack  <= 1'b0;
         st_al    <= 1'b0;
         done     <= 1'b0;
         cmd_q    <= CMD_NONE;
      end else begin
         state    <= state_nxt;
         desc     <= desc_nxt;
         cnt      <= cnt_nxt;
         din_q    <= din_nxt;
         rd_data  <= rd_data_nxt;
         rd_valid <= rd_valid_nxt;
         st_nack  <= st_nack_nxt;
         st_al    <= st_al_nxt;
         done     <= done_nxt;
         cmd_q    <= cmd_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      desc_nxt     = desc;
      cnt_nxt      = cnt;
      din_nxt      = din_q;
      rd_data_nxt  = rd_data;
      rd_valid_nxt = rd_valid;
      st_nack_nxt  = st_nack;
      st_al_nxt    = st_al;
      if (al_hit) begin
         // Lost arbitration: abandon the bus without a STOP.
         state_nxt    = IDLE;
         rd_valid_nxt = 1'b0;
         st_al_nxt    = 1'b1;
      end else begin
         case (state)
            IDLE: if (accept) begin
               desc_nxt    = '{rnw: req_rnw, stop: req_stop,
                               len_zero: (req_len == '0)};
               cnt_nxt     = req_len;
               din_nxt     = {req_addr, req_rnw};
               st_nack_nxt = 1'b0;
               st_al_nxt   = 1'b0;
               state_nxt   = ADDR;
            end
            ADDR: if (bc.cmd_ack) begin
               if (bc.ack_out) begin
                  st_nack_nxt = 1'b1;
                  state_nxt   = (desc.len_zero & desc.stop) ? DONE : NACK_STOP;
               end else if (desc.len_zero) state_nxt = DONE;
               else if (desc.rnw)          state_nxt = RD;
               else                        state_nxt = WR_WAIT;
            end
            WR_WAIT: if (wr_valid) begin
               din_nxt   = wr_data;
               state_nxt = WR;
            end
            WR: if (bc.cmd_ack) begin
               cnt_nxt = cnt - LEN_W'(1);
               if (bc.ack_out) begin
                  st_nack_nxt = 1'b1;
                  state_nxt   = cnt_last ? DONE : NACK_STOP;
               end else begin
                  state_nxt = cnt_last ? DONE : WR_WAIT;
               end
            end
            RD: if (bc.cmd_ack) begin
               rd_data_nxt  = bc.dout;
               rd_valid_nxt = 1'b1;
               cnt_nxt      = cnt - LEN_W'(1);
               state_nxt    = RD_HOLD;
            end
            RD_HOLD: if (rd_valid & rd_ready) begin
               rd_valid_nxt = 1'b0;
               state_nxt    = (cnt == '0) ? DONE : RD;
            end
            NACK_STOP: if (bc.cmd_ack) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // Commands are registered from the state being entered, so they appear
   // together with the state and drop on the edge after cmd_ack.
   always_comb begin
      cmd_nxt  = cmd_for(state_nxt, cnt_nxt == LEN_W'(1), desc_nxt.stop,
                         desc_nxt.len_zero);
      done_nxt = (state_nxt == DONE) | (al_hit & (state != DONE));
   end

endmodule

// File: doc/i2c_xfer_seq.md
Name: i2c_xfer_seq

Overview:
Master-side transaction sequencer directly upstream of i2c_master_byte_ctrl. It accepts one transaction descriptor (7-bit slave address, direction, byte count, stop flag), drives the byte controller's start/stop/read/write/ack_in/din command interface, and consumes cmd_ack/ack_out/dout. It streams TX bytes in and RX bytes out over valid/ready, and reports completion, NACK and arbitration loss. Master mode only; it never issues commands while the slave path is active.

Parameters:
LEN_W, 8, width of req_len; a transaction carries 0..2^LEN_W-1 data bytes

Ports:
clk  in  1  clock
nReset  in  1  synchronous active-low reset
req_valid  in  1  descriptor valid
req_ready  out  1  high only in IDLE
req_addr  in  7  slave address
req_rnw  in  1  1 = read, 0 = write
req_len  in  LEN_W  data byte count; 0 = address-only probe
req_stop  in  1  1 = end with STOP; 0 = keep bus for a repeated start
wr_data  in  8  TX byte
wr_valid  in  1  TX byte valid
wr_ready  out  1  TX byte accepted this cycle
rd_data  out  8  RX byte, stable while rd_valid
rd_valid  out  1  RX byte valid
rd_ready  in  1  RX byte consumed
done  out  1  one-cycle pulse at transaction end
st_nack  out  1  last transaction ended on NACK (held until next accept)
st_al  out  1  last transaction ended on arbitration loss (held)
start, stop, read, write  out  1 each  byte-controller commands
ack_in  out  1  ACK bit sent after a read byte (0 = ACK, 1 = NACK)
din  out  8  byte to byte controller
cmd_ack  in  1  byte-controller command done pulse
ack_out  in  1  received ACK bit (1 = NACK)
dout  in  8  byte from byte controller
i2c_al  in  1  arbitration lost
slave_act  in  1  slave path owns the controller

Behaviour:
- Reset (nReset low at clk edge): state IDLE. All outputs 0 except req_ready = 1. Byte counter 0. Reset mid-transfer drops commands immediately; the byte controller is reset by the same system reset.
- All command outputs are registered. A command is held stable until cmd_ack is sampled high and is cleared on the following edge. Because the byte controller gates go with ~cmd_ack, no command is reissued.
- IDLE: when req_valid & ~slave_act, latch the descriptor, set cnt = req_len, clear st_nack and st_al, and go to ADDR.
- ADDR: start = 1, write = 1, din = {addr, rnw}. If len == 0 and stop_f, stop = 1 as well. On cmd_ack:
  - ack_out = 1 → NACK_STOP (or DONE if stop was already included), set st_nack.
  - len == 0 → DONE.
  - rnw → RD.
  - otherwise → WR_WAIT.
- WR_WAIT: wr_ready = wr_valid; on a handshake, latch wr_data into din and go to WR. Stall indefinitely with the bus held.
- WR: write = 1; stop = (cnt == 1) & stop_f. On cmd_ack, cnt-- and:
  - ack_out = 1 with cnt > 1 → NACK_STOP, set st_nack.
  - ack_out = 1 on the last byte → set st_nack, then DONE.
  - cnt reaches 0 → DONE.
  - otherwise → WR_WAIT.
- RD: read = 1; ack_in = (cnt == 1), i.e. NACK on the last byte only; stop = (cnt == 1) & stop_f. On cmd_ack: rd_data = dout, rd_valid = 1, cnt--, go to RD_HOLD.
- RD_HOLD: on rd_valid & rd_ready, clear rd_valid; go to DONE if cnt == 0, else RD. The next read is never issued while rd_valid is high.
- NACK_STOP: stop = 1 alone; on cmd_ack → DONE.
- DONE: done = 1 for one cycle → IDLE.
- i2c_al high in any non-IDLE state has priority over everything else: clear commands and rd_valid, set st_al, pulse done, go to IDLE. No STOP is issued.
- Simultaneous cmd_ack and i2c_al: the al path wins.
- req_stop = 0: after DONE the bus stays owned; the next descriptor's ADDR produces a repeated start.
- cnt is LEN_W bits and never wraps; it decrements only on cmd_ack in WR or RD.

Decomposition:
- i2c_package gains a state enum t_seq_state: IDLE, ADDR, WR_WAIT, WR, RD, RD_HOLD, NACK_STOP, DONE.
- No sub-module; single FSM plus a counter and data registers.

Test Plan:
- Write addr 0x50, len 2, bytes 0xA5, 0x3C, stop=1, all ACK → din sequence 0xA0, 0xA5, 0x3C; stop asserted with the second write; one done pulse; st_nack = 0.
- Read addr 0x21, len 3, slave returns 0x11, 0x22, 0x33 → din 0x43; ack_in 0, 0, 1; rd_data 0x11, 0x22, 0x33 in order. Hold rd_ready low 10 cycles after the first byte → no read command during the stall.
- Probe addr 0x7F, len 0, NACK → start+write+stop issued together; st_nack = 1; done pulse; req_ready back high.
- Write len 3 with NACK on byte 1 → a separate stop-only command follows; st_nack = 1; the remaining bytes are never requested (wr_ready stays 0).
- i2c_al pulses during the second read byte → all commands drop next cycle; rd_valid = 0; st_al = 1; done pulse; no stop command.
- Write len 1 with stop=0, then read len 1 → the second start is issued without an intervening stop; nReset low mid-transfer → req_ready = 1 and all commands 0 next cycle.
